// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply-unit issue controller: op codes, FSM states,
// the supported-op test and the value reported when the unit times out.
package mdu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 8;
    localparam int RD_W   = 5;

    localparam logic [OP_W-1:0] OP_NOP   = 8'h00;
    localparam logic [OP_W-1:0] OP_MUL   = 8'h01;
    localparam logic [OP_W-1:0] OP_MULH  = 8'h02;
    localparam logic [OP_W-1:0] OP_MULHU = 8'h03;

    localparam logic [DATA_W-1:0] TIMEOUT_RESULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } mdu_state_e;

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/mdu_wdog.sv
// Watchdog counter for the issue controller: counts cycles spent waiting on the unit
// and flags expiry on the TIMEOUT_CYCLES-th cycle. Only built when MDU_TIMEOUT_EN is set.
module mdu_wdog #(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of completed waiting cycles, so the N-th cycle sees N-1.
    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/handshake controller between the EX stage and a multi-cycle multiply unit.
// Define MDU_TIMEOUT_EN to build the WAIT/DRAIN watchdog (mdu_wdog).
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic [OP_W-1:0]   fu_op,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    input  logic              fu_done,
    input  logic [DATA_W-1:0] fu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              busy,
    output logic              timeout_err
);

    mdu_state_e state;
    logic       accept;
    logic       wd_expired;

    // A request is taken when idle or when the held result leaves this same cycle.
    assign in_ready = !flush && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

`ifdef MDU_TIMEOUT_EN
    logic wd_restart;
    logic wd_run;

    assign wd_run     = (state == ST_WAIT) || (state == ST_DRAIN);
    assign wd_restart = (accept && op_supported(in_op)) ||
                        ((state == ST_WAIT) && flush && !fu_done);

    mdu_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .restart (wd_restart),
        .run     (wd_run),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expired         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            fu_op       <= OP_NOP;
            fu_a        <= '0;
            fu_b        <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (flush) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_rd <= in_rd;
                        if (op_supported(in_op)) begin
                            state     <= ST_WAIT;
                            fu_op     <= in_op;
                            fu_a      <= in_a;
                            fu_b      <= in_b;
                            out_valid <= 1'b0;
                        end else begin
                            state      <= ST_HOLD;
                            out_result <= '0;
                            out_valid  <= 1'b1;
                        end
                    end else if ((state == ST_HOLD) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    // A flush landing on the completion cycle has nothing left to drain.
                    if (fu_done) begin
                        fu_op <= OP_NOP;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state      <= ST_HOLD;
                            out_result <= fu_result;
                            out_valid  <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                        fu_op <= OP_NOP;
                    end else if (wd_expired) begin
                        state       <= ST_HOLD;
                        fu_op       <= OP_NOP;
                        out_result  <= TIMEOUT_RESULT;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (fu_done) begin
                        state <= ST_IDLE;
                    end else if (wd_expired) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed scenarios plus a randomized run
// against a transaction-level scoreboard; the bench also plays the multiply unit.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

`ifdef MDU_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 63;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_op = 8'h00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic [7:0]  fu_op;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        fu_done = 1'b0;
    logic [31:0] fu_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;
    logic        timeout_err;

    mdu_issue_ctrl #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_rd      (in_rd),
        .flush      (flush),
        .fu_op      (fu_op),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_done    (fu_done),
        .fu_result  (fu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] res; } res_t;
    typedef struct packed { logic [7:0] op; logic [31:0] a; logic [31:0] b; } iss_t;

    res_t exp_q[$];
    iss_t iss_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        auto_fu   = 1'b1;
    int          force_lat = 0;
    int          fu_age    = 0;
    int          fu_lat    = 1;
    logic        in_drain  = 1'b0;
    logic [7:0]  prev_op   = 8'h00;
    logic [31:0] prev_a    = '0;
    logic [31:0] prev_b    = '0;
    logic [31:0] prev_res  = '0;
    logic [4:0]  prev_rd   = '0;
    logic        prev_done = 1'b0;
    logic        prev_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_supported(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
    endfunction

    function automatic logic [31:0] mul_ref(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        pu;
        logic signed [63:0] ps;
        pu = {32'd0, a} * {32'd0, b};
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            8'h01:   return pu[31:0];
            8'h02:   return ps[63:32];
            8'h03:   return pu[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    // Start of a cycle: registered outputs are settled; run monitors and the unit model.
    task automatic cyc_begin();
        iss_t ei;
        @(negedge clk);
        if (prev_done) chk("no_retrigger", {24'd0, fu_op}, 32'd0);
        if (prev_op != 8'h00 && fu_op != 8'h00) begin
            chk("fu_op_stable", {24'd0, fu_op}, {24'd0, prev_op});
            chk("fu_a_stable", fu_a, prev_a);
            chk("fu_b_stable", fu_b, prev_b);
        end
        if (prev_op == 8'h00 && fu_op != 8'h00) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_issue", {24'd0, fu_op}, 32'd0);
            end else begin
                ei = iss_q.pop_front();
                chk("issue_op", {24'd0, fu_op}, {24'd0, ei.op});
                chk("issue_a", fu_a, ei.a);
                chk("issue_b", fu_b, ei.b);
            end
            fu_age = 0;
            fu_lat = (force_lat != 0) ? force_lat : $urandom_range(1, 5);
        end
        if (prev_hold) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", out_result, prev_res);
            chk("hold_rd", {27'd0, out_rd}, {27'd0, prev_rd});
        end
        fu_done   = 1'b0;
        fu_result = $urandom;
        if (fu_op != 8'h00) begin
            fu_age++;
            if (auto_fu && fu_age == fu_lat) begin
                fu_done   = 1'b1;
                fu_result = mul_ref(fu_op, fu_a, fu_b);
            end
        end
        prev_op = fu_op;
        prev_a  = fu_a;
        prev_b  = fu_b;
    endtask

    // End of a cycle: inputs are driven; evaluate handshakes and update the scoreboard.
    task automatic cyc_end();
        logic acc;
        logic pop;
        logic exp_ready;
        res_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            iss_q.delete();
            prev_hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            acc = in_valid && in_ready;
            pop = out_valid && out_ready && !flush;
            if (out_valid) chk("valid_has_result", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (!in_drain) begin
                exp_ready = !flush && ((exp_q.size() == 0) || (out_valid && out_ready));
                chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_result", out_result, e.res);
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                end
            end
            if (flush) begin
                exp_q.delete();
                iss_q.delete();
            end
            if (acc) begin
                e.rd  = in_rd;
                e.res = tb_supported(in_op) ? mul_ref(in_op, in_a, in_b) : 32'd0;
                exp_q.push_back(e);
                if (tb_supported(in_op)) iss_q.push_back('{op: in_op, a: in_a, b: in_b});
            end
            prev_hold = out_valid && !pop && !flush;
            prev_done = fu_done;
        end
        prev_res = out_result;
        prev_rd  = out_rd;
    endtask

    initial begin
        int         r;
        logic [7:0] op;

        repeat (3) begin
            cyc_begin();
            cyc_end();
        end
        cyc_begin();
        rst = 1'b0;
        chk("rst_fu_op", {24'd0, fu_op}, 32'd0);
        chk("rst_fu_a", fu_a, 32'd0);
        chk("rst_fu_b", fu_b, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cyc_end();

        // OP_MUL 3*5, unit completes in the 4th cycle of issue
        force_lat = 4;
        out_ready = 1'b1;
        cyc_begin();
        set_in(1'b1, OP_MUL, 32'd3, 32'd5, 5'd7);
        cyc_end();
        chk("t37_accept", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc_begin();
            set_in(1'b0, OP_NOP, '0, '0, '0);
            chk("t37_wait_valid", {31'd0, out_valid}, 32'd0);
            chk("t37_wait_fu_op", {24'd0, fu_op}, {24'd0, OP_MUL});
            cyc_end();
        end
        cyc_begin();
        chk("t37_valid", {31'd0, out_valid}, 32'd1);
        chk("t37_result", out_result, 32'h0000_000F);
        chk("t37_fu_nop", {24'd0, fu_op}, 32'd0);
        cyc_end();
        cyc_begin();
        chk("t37_idle", {31'd0, busy}, 32'd0);
        cyc_end();

        // Back-to-back OP_MULH
        force_lat = 2;
        cyc_begin();
        set_in(1'b1, OP_MULH, 32'hFFFF_FFF9, 32'd3, 5'd1);
        cyc_end();
        cyc_begin();
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        cyc_begin();
        cyc_end();
        cyc_begin();
        chk("t38_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t38_gap_nop", {24'd0, fu_op}, 32'd0);
        set_in(1'b1, OP_MULH, 32'h8000_0000, 32'd2, 5'd2);
        cyc_end();
        chk("t38_b2b_ready", {31'd0, in_ready}, 32'd1);
        cyc_begin();
        chk("t38_reissue", {24'd0, fu_op}, {24'd0, OP_MULH});
        chk("t38_valid_low", {31'd0, out_valid}, 32'd0);
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        repeat (3) begin
            cyc_begin();
            cyc_end();
        end
        chk("t38_drained", exp_q.size(), 32'd0);

        // Result held for 10 cycles under back-pressure
        force_lat = 1;
        out_ready = 1'b0;
        cyc_begin();
        set_in(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        cyc_end();
        cyc_begin();
        set_in(1'b1, OP_MUL, 32'd1, 32'd1, 5'd9);
        cyc_end();
        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            chk("t39_valid", {31'd0, out_valid}, 32'd1);
            chk("t39_fu_nop", {24'd0, fu_op}, 32'd0);
            cyc_end();
            chk("t39_ready_low", {31'd0, in_ready}, 32'd0);
        end
        cyc_begin();
        chk("t39_result", out_result, 32'hFFFF_FFFE);
        set_in(1'b0, OP_NOP, '0, '0, '0);
        out_ready = 1'b1;
        cyc_end();

        // Flush two cycles into WAIT, late completion is drained
        auto_fu   = 1'b0;
        force_lat = 0;
        cyc_begin();
        set_in(1'b1, OP_MUL, 32'd11, 32'd2, 5'd4);
        cyc_end();
        cyc_begin();
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        cyc_begin();
        flush = 1'b1;
        cyc_end();
        in_drain = 1'b1;
        cyc_begin();
        flush = 1'b0;
        chk("t40_drain_fu_nop", {24'd0, fu_op}, 32'd0);
        chk("t40_drain_busy", {31'd0, busy}, 32'd1);
        set_in(1'b1, OP_MUL, 32'd1, 32'd1, 5'd1);
        cyc_end();
        chk("t40_drain_ready", {31'd0, in_ready}, 32'd0);
        cyc_begin();
        cyc_end();
        cyc_begin();
        fu_done   = 1'b1;
        fu_result = 32'h0000_1234;
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        in_drain = 1'b0;
        cyc_begin();
        chk("t40_idle", {31'd0, busy}, 32'd0);
        chk("t40_no_valid", {31'd0, out_valid}, 32'd0);
        auto_fu   = 1'b1;
        force_lat = 3;
        set_in(1'b1, OP_MUL, 32'd7, 32'd6, 5'd10);
        cyc_end();
        chk("t40_next_accept", {31'd0, in_ready}, 32'd1);
        cyc_begin();
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        cyc_begin();
        cyc_end();
        cyc_begin();
        cyc_end();
        cyc_begin();
        chk("t40_next_result", out_result, 32'd42);
        cyc_end();
        cyc_begin();
        cyc_end();
        chk("t40_drained", exp_q.size(), 32'd0);

        // Unsupported op answers with zero and never issues
        out_ready = 1'b0;
        cyc_begin();
        set_in(1'b1, 8'hFF, $urandom, $urandom, 5'd5);
        cyc_end();
        cyc_begin();
        chk("t41_valid", {31'd0, out_valid}, 32'd1);
        chk("t41_result", out_result, 32'd0);
        chk("t41_fu_nop", {24'd0, fu_op}, 32'd0);
        set_in(1'b0, OP_NOP, '0, '0, '0);
        out_ready = 1'b1;
        cyc_end();
        cyc_begin();
        chk("t41_valid_low", {31'd0, out_valid}, 32'd0);
        cyc_end();

        // Stray completion while idle, and flush blocking a request
        cyc_begin();
        fu_done   = 1'b1;
        fu_result = 32'h0000_0555;
        cyc_end();
        cyc_begin();
        chk("t30_no_valid", {31'd0, out_valid}, 32'd0);
        chk("t30_idle", {31'd0, busy}, 32'd0);
        flush = 1'b1;
        set_in(1'b1, OP_MUL, 32'd2, 32'd3, 5'd12);
        cyc_end();
        chk("t29_flush_blocks", {31'd0, in_ready}, 32'd0);
        cyc_begin();
        flush = 1'b0;
        set_in(1'b0, OP_NOP, '0, '0, '0);
        chk("t29_idle", {31'd0, busy}, 32'd0);
        chk("t29_fu_nop", {24'd0, fu_op}, 32'd0);
        cyc_end();

        // Reset in the middle of WAIT abandons the op
        auto_fu = 1'b0;
        cyc_begin();
        set_in(1'b1, OP_MUL, 32'd4, 32'd4, 5'd11);
        cyc_end();
        cyc_begin();
        set_in(1'b0, OP_NOP, '0, '0, '0);
        cyc_end();
        cyc_begin();
        rst   = 1'b1;
        flush = 1'b1;
        cyc_end();
        cyc_begin();
        rst   = 1'b0;
        flush = 1'b0;
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_fu_nop", {24'd0, fu_op}, 32'd0);
        chk("rstw_valid", {31'd0, out_valid}, 32'd0);
        cyc_end();
        auto_fu = 1'b1;

`ifdef MDU_TIMEOUT_EN
        // Unit never answers: watchdog reports after TB_TIMEOUT waiting cycles
        auto_fu   = 1'b0;
        out_ready = 1'b0;
        cyc_begin();
        set_in(1'b1, OP_MUL, 32'd2, 32'd2, 5'd6);
        cyc_end();
        exp_q[0].res = 32'hDEAD_BEEF;
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            cyc_begin();
            set_in(1'b0, OP_NOP, '0, '0, '0);
            chk("to_wait_valid", {31'd0, out_valid}, 32'd0);
            chk("to_wait_fu_op", {24'd0, fu_op}, {24'd0, OP_MUL});
            cyc_end();
        end
        cyc_begin();
        chk("to_valid", {31'd0, out_valid}, 32'd1);
        chk("to_result", out_result, 32'hDEAD_BEEF);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_fu_nop", {24'd0, fu_op}, 32'd0);
        out_ready = 1'b1;
        cyc_end();
        repeat (2) begin
            cyc_begin();
            chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
            cyc_end();
        end
        cyc_begin();
        rst = 1'b1;
        cyc_end();
        cyc_begin();
        rst = 1'b0;
        chk("to_err_cleared", {31'd0, timeout_err}, 32'd0);
        cyc_end();
        auto_fu = 1'b1;
`endif

        // Randomized traffic against the scoreboard
        force_lat = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cyc_begin();
            r = $urandom_range(0, 4);
            case (r)
                0:       op = OP_MUL;
                1:       op = OP_MULH;
                2:       op = OP_MULHU;
                default: op = 8'($urandom);
            endcase
            set_in(1'($urandom_range(0, 1)), op, $urandom, $urandom, 5'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc_end();
        end
        cyc_begin();
        set_in(1'b0, OP_NOP, '0, '0, '0);
        out_ready = 1'b1;
        cyc_end();
        repeat (20) begin
            cyc_begin();
            cyc_end();
        end
        chk("final_results_empty", exp_q.size(), 32'd0);
        chk("final_issues_empty", iss_q.size(), 32'd0);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
